// File: rtl/vector_load_store_unit.sv
// Vector load/store unit: moves one LANES-element vector between a
// register-side bundle and word-addressed memory, one lane per cycle.
module vector_load_store_unit #(
    parameter int LANES         = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          isStore,
    input  logic [ADDRESS_WIDTH-1:0]      baseAddress,
    input  logic [LANES*DATA_WIDTH-1:0]   storeVector,
    output logic                          busy,
    output logic                          done,
    output logic [LANES*DATA_WIDTH-1:0]   loadVector,
    output logic [ADDRESS_WIDTH-1:0]      memReadAddress,
    input  logic [DATA_WIDTH-1:0]         memReadData,
    output logic [ADDRESS_WIDTH-1:0]      memWriteAddress,
    output logic [DATA_WIDTH-1:0]         memWriteData,
    output logic                          memWriteEnable
);

    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CW-1:0] LAST_LANE = CW'(LANES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STORE,
        DONE
    } state_t;

    state_t                        state;
    logic [CW-1:0]                 lane;
    logic [ADDRESS_WIDTH-1:0]      base;
    logic                          op;
    logic [LANES*DATA_WIDTH-1:0]   storeLatch;
    logic [ADDRESS_WIDTH-1:0]      laneAddress;

    // Lane address wraps modulo 2^ADDRESS_WIDTH; lane is 0 outside transfers
    assign laneAddress = base + ADDRESS_WIDTH'(lane);

    // Status and memory-side outputs decoded from registered state only
    always_comb begin
        busy            = (state == LOAD) || (state == STORE);
        done            = (state == DONE);
        memReadAddress  = laneAddress;
        memWriteAddress = laneAddress;
        memWriteEnable  = (state == STORE) && op;
        memWriteData    = '0;
        if (state == STORE) begin
            memWriteData = storeLatch[lane*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Transfer FSM: accept in IDLE, walk lanes ascending, pulse DONE once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lane       <= '0;
            base       <= '0;
            op         <= 1'b0;
            storeLatch <= '0;
            loadVector <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base       <= baseAddress;
                        op         <= isStore;
                        storeLatch <= storeVector;
                        lane       <= '0;
                        state      <= isStore ? STORE : LOAD;
                    end
                end
                LOAD: begin
                    loadVector[lane*DATA_WIDTH +: DATA_WIDTH] <= memReadData;
                    if (lane == LAST_LANE) begin
                        lane  <= '0;
                        state <= DONE;
                    end else begin
                        lane <= lane + 1'b1;
                    end
                end
                STORE: begin
                    if (lane == LAST_LANE) begin
                        lane  <= '0;
                        state <= DONE;
                    end else begin
                        lane <= lane + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_load_store_unit.sv
// Directed bench for vector_load_store_unit with a small behavioural
// memory that logs every write it accepts.
module tb_vector_load_store_unit;

    localparam int L  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam logic [127:0] LV_ABCD = {32'hD, 32'hC, 32'hB, 32'hA};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            isStore = 1'b0;
    logic [AW-1:0]   baseAddress = '0;
    logic [L*DW-1:0] storeVector = '0;
    logic            busy;
    logic            done;
    logic [L*DW-1:0] loadVector;
    logic [AW-1:0]   memReadAddress;
    logic [DW-1:0]   memReadData;
    logic [AW-1:0]   memWriteAddress;
    logic [DW-1:0]   memWriteData;
    logic            memWriteEnable;

    logic [31:0] mem [0:255];
    logic [31:0] wa  [0:63];
    logic [31:0] wd  [0:63];
    int          wn = 0;
    logic        pl_en = 1'b0;
    logic [31:0] pl_addr = '0;
    logic [31:0] pl_data = '0;

    int tests = 0;
    int fails = 0;
    int w0;
    logic [31:0] wrapA [0:3];

    vector_load_store_unit #(
        .LANES(L), .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .isStore(isStore),
        .baseAddress(baseAddress),
        .storeVector(storeVector),
        .busy(busy),
        .done(done),
        .loadVector(loadVector),
        .memReadAddress(memReadAddress),
        .memReadData(memReadData),
        .memWriteAddress(memWriteAddress),
        .memWriteData(memWriteData),
        .memWriteEnable(memWriteEnable)
    );

    always #5 clk = ~clk;

    assign memReadData = mem[memReadAddress[7:0]];

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr[7:0]] <= pl_data;
        end else if (memWriteEnable) begin
            mem[memWriteAddress[7:0]] <= memWriteData;
            wa[wn] <= memWriteAddress;
            wd[wn] <= memWriteData;
            wn     <= wn + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pl(input logic [31:0] a, input logic [31:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        tick();
        pl_en   = 1'b0;
    endtask

    initial begin
        wrapA[0] = 32'hFFFF_FFFE;
        wrapA[1] = 32'hFFFF_FFFF;
        wrapA[2] = 32'h0000_0000;
        wrapA[3] = 32'h0000_0001;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            pl(32'(100 + i), 32'(10 + i));
            pl(32'(200 + i), 32'h0);
            pl(32'(64 + i), 32'h55);
        end

        // reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wen", memWriteEnable, 0);
        check("rst_wdata", memWriteData, 0);
        check("rst_raddr", memReadAddress, 0);
        check("rst_waddr", memWriteAddress, 0);
        check("rst_lv", loadVector, 0);
        rst = 1'b0;

        // load from 100: done after 5 edges counting the start edge
        start = 1'b1; isStore = 1'b0; baseAddress = 32'd100;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("ld_busy", busy, 1);
            check("ld_raddr", memReadAddress, 100 + i);
            check("ld_wen", memWriteEnable, 0);
            check("ld_done", done, 0);
            tick();
        end
        check("ld_done_hi", done, 1);
        check("ld_busy_done", busy, 0);
        check("ld_lv", loadVector, LV_ABCD);
        check("ld_raddr_done", memReadAddress, 100);
        tick();
        check("ld_done_lo", done, 0);
        check("ld_idle_busy", busy, 0);

        // store 1..4 to 200; loadVector must hold
        start = 1'b1; isStore = 1'b1; baseAddress = 32'd200;
        storeVector = {32'd4, 32'd3, 32'd2, 32'd1};
        w0 = wn;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("st_wen", memWriteEnable, 1);
            check("st_waddr", memWriteAddress, 200 + i);
            check("st_wdata", memWriteData, i + 1);
            check("st_lv_hold", loadVector, LV_ABCD);
            tick();
        end
        check("st_done", done, 1);
        check("st_wen_done", memWriteEnable, 0);
        check("st_wdata_done", memWriteData, 0);
        check("st_nwrites", wn - w0, 4);
        for (int i = 0; i < 4; i++) begin
            check("st_mem", mem[8'(200 + i)], i + 1);
        end
        tick();

        // start held high: one transfer, re-accepted only from IDLE
        start = 1'b1; isStore = 1'b0; baseAddress = 32'd100;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("hold_busy", busy, 1);
            tick();
        end
        check("hold_done", done, 1);
        check("hold_busy_done", busy, 0);
        tick();
        check("hold_idle_busy", busy, 0);
        check("hold_idle_done", done, 0);
        tick();
        check("hold_reaccept", busy, 1);
        for (int i = 0; i < 4; i++) tick();
        check("hold_done2", done, 1);
        start = 1'b0;
        tick();
        check("hold_end_busy", busy, 0);

        // store across the address wrap; loadVector holds
        start = 1'b1; isStore = 1'b1; baseAddress = 32'hFFFF_FFFE;
        storeVector = {32'h40, 32'h30, 32'h20, 32'h10};
        w0 = wn;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("wrap_waddr", memWriteAddress, wrapA[i]);
            check("wrap_lv_hold", loadVector, LV_ABCD);
            tick();
        end
        check("wrap_done", done, 1);
        check("wrap_nwrites", wn - w0, 4);
        for (int i = 0; i < 4; i++) begin
            check("wrap_log_addr", wa[w0 + i], wrapA[i]);
            check("wrap_log_data", wd[w0 + i], 32'h10 * (i + 1));
        end
        tick();

        // reset after two store lanes aborts at once
        start = 1'b1; isStore = 1'b1; baseAddress = 32'd64;
        storeVector = {32'h99, 32'h88, 32'h77, 32'h66};
        w0 = wn;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort_pre_wen", memWriteEnable, 1);
        check("abort_pre_n", wn - w0, 2);
        rst = 1'b1;
        #1;
        check("abort_wen", memWriteEnable, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_lv", loadVector, 0);
        check("abort_waddr", memWriteAddress, 0);
        check("abort_wdata", memWriteData, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("abort_rst_done", done, 0);
        end
        rst = 1'b0;
        tick();
        check("abort_after_done", done, 0);
        check("abort_nwrites", wn - w0, 2);
        check("abort_mem0", mem[8'd64], 32'h66);
        check("abort_mem1", mem[8'd65], 32'h77);
        check("abort_mem2", mem[8'd66], 32'h55);
        check("abort_mem3", mem[8'd67], 32'h55);

        // first start after reset is accepted normally
        start = 1'b1; isStore = 1'b0; baseAddress = 32'd100;
        tick();
        start = 1'b0;
        check("post_rst_busy", busy, 1);
        for (int i = 0; i < 4; i++) tick();
        check("post_rst_done", done, 1);
        check("post_rst_lv", loadVector, LV_ABCD);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
